// File: rtl/sdm_decim_cic_pkg.sv
// rtl/sdm_decim_cic_pkg.sv - shared CIC sizing constants and helpers for the sigma-delta decimator
// Provides the filter order, the internal accumulator width and the output alignment shift.
package sdm_decim_cic_pkg;

    localparam int CIC_ORDER = 3;

    // Internal width: order*log2(R) bits of gain plus sign plus one bit of headroom
    // so the full-scale comb output (+/-2**(3*LOG2R)) is representable.
    function automatic int cic_width(input int log2r);
        return CIC_ORDER * log2r + 2;
    endfunction

    // Right shift that maps the comb full-scale onto a BITS-wide signed sample.
    function automatic int cic_out_shift(input int log2r, input int bits);
        return CIC_ORDER * log2r - (bits - 1);
    endfunction

endpackage

// File: rtl/sdm_decim_cic_integrator.sv
// rtl/sdm_decim_cic_integrator.sv - W-bit enabled wrapping accumulator, one CIC integrator stage
// Ports:
//   clk    in   1   system clock
//   reset  in   1   asynchronous active-high clear
//   en     in   1   accumulate x this cycle
//   x      in   W   signed increment
//   acc    out  W   registered accumulator value (wraps modulo 2**W)
module sdm_decim_cic_integrator #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] acc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + x;
        end
    end

endmodule

// File: rtl/sdm_decim_cic.sv
// rtl/sdm_decim_cic.sv - 3rd-order CIC decimator turning a 1-bit sigma-delta stream into PCM
// Ports:
//   clk         in   1     system clock, all state on rising edge
//   reset       in   1     asynchronous active-high clear
//   bit_en      in   1     qualifies din
//   din         in   1     bitstream bit, 1 -> +1, 0 -> -1
//   dout        out  BITS  decimated signed sample, held between strobes
//   dout_valid  out  1     one-cycle pulse per decimated sample
//   settled     out  1     sticky, high from the third sample after reset
module sdm_decim_cic
    import sdm_decim_cic_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int LOG2R = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bit_en,
    input  logic            din,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    output logic            settled
);

    localparam int W     = cic_width(LOG2R);
    localparam int SHIFT = cic_out_shift(LOG2R, BITS);

    localparam logic [BITS-1:0] OUT_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] OUT_MIN = {1'b1, {(BITS-1){1'b0}}};

    logic signed [W-1:0] x;
    logic signed [W-1:0] i1, i2, i3;
    logic signed [W-1:0] s1, s2;
    logic signed [W-1:0] d1, d2, d3;
    logic signed [W-1:0] c1, c2, c3;
    logic signed [W-1:0] c3_shr;
    logic [W-BITS:0]     c3_top;
    logic [BITS-1:0]     sat_val;

    logic [LOG2R-1:0] phase;
    logic             tick;
    logic             tick_q;
    logic             tick_d;
    logic [1:0]       vcnt;

    assign x = din ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    // Cascade: each stage accumulates the already-updated value of the stage before it.
    assign s1 = i1 + x;
    assign s2 = i2 + s1;

    sdm_decim_cic_integrator #(.W(W)) u_int1 (
        .clk   (clk),
        .reset (reset),
        .en    (bit_en),
        .x     (x),
        .acc   (i1)
    );

    sdm_decim_cic_integrator #(.W(W)) u_int2 (
        .clk   (clk),
        .reset (reset),
        .en    (bit_en),
        .x     (s1),
        .acc   (i2)
    );

    sdm_decim_cic_integrator #(.W(W)) u_int3 (
        .clk   (clk),
        .reset (reset),
        .en    (bit_en),
        .x     (s2),
        .acc   (i3)
    );

    // R-th qualified bit of a period; comb runs on the following cycle so that
    // i3 already contains that bit (and not any bit arriving alongside tick_q).
    assign tick = bit_en && (phase == {LOG2R{1'b1}});

    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    assign c3_shr = c3 >>> SHIFT;
    assign c3_top = c3_shr[W-1:BITS-1];

    // The chain itself wraps freely; only the final sample is clamped.
    always_comb begin
        sat_val = c3_shr[BITS-1:0];
        if ((c3_top != '0) && (c3_top != '1)) begin
            sat_val = c3_shr[W-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            tick_q     <= 1'b0;
            tick_d     <= 1'b0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            settled    <= 1'b0;
            vcnt       <= '0;
        end else begin
            if (bit_en) begin
                phase <= phase + 1'b1;
            end
            tick_q     <= tick;
            tick_d     <= tick_q;
            dout_valid <= tick_d;
            if (tick_q) begin
                d1   <= i3;
                d2   <= c1;
                d3   <= c2;
                dout <= sat_val;
            end
            // settled rises together with the third dout_valid pulse.
            if (tick_d) begin
                if (vcnt == 2'd2) begin
                    settled <= 1'b1;
                end else begin
                    vcnt <= vcnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdm_decim_cic.sv
// tb/tb_sdm_decim_cic.sv - self-checking bench for sdm_decim_cic
module tb_sdm_decim_cic;

    localparam int BITS  = 16;
    localparam int LOG2R = 6;
    localparam int R     = 64;
    localparam int HL    = 3 * R - 2;
    localparam int SH    = 3 * LOG2R - (BITS - 1);

    logic            clk = 1'b0;
    logic            reset;
    logic            bit_en;
    logic            din;
    logic [BITS-1:0] dout;
    logic            dout_valid;
    logic            settled;

    always #5 clk = ~clk;

    sdm_decim_cic #(.BITS(BITS), .LOG2R(LOG2R)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .settled    (settled)
    );

    typedef struct {
        logic [15:0] dout;
        logic        settled;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  pat;
        int          plen;
        int          duty;
        logic [15:0] exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   h[HL];
    int   hist[HL];
    int   nb;
    int   n_strobe;
    exp_t sb[$];
    logic [15:0] last_dout;

    logic [7:0] pat;
    int         plen;
    int         pidx;
    logic       use_mod;
    int         mod_acc;
    int         mod_code;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer.
    exp_t e_mon;
    always @(posedge clk) begin
        #1;
        if (dout_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("dout", {16'd0, dout}, {16'd0, e_mon.dout});
                check("settled", {31'd0, settled}, {31'd0, e_mon.settled});
                check("strobe_cycle", cyc, e_mon.cyc);
            end
            last_dout = dout;
        end
    end

    // Reference: direct FIR with the triple-boxcar impulse response.
    task automatic model_bit(input logic b);
        int   y;
        exp_t e;
        for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = b ? 1 : -1;
        nb++;
        if (nb % R == 0) begin
            y = 0;
            for (int k = 0; k < HL; k++) y += h[k] * hist[k];
            y = y >>> SH;
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
            n_strobe++;
            e.dout    = y[15:0];
            e.settled = (n_strobe >= 3);
            e.cyc     = cyc + 3;
            sb.push_back(e);
        end
    endtask

    function automatic logic gen_bit();
        logic y;
        if (use_mod) begin
            y = (mod_acc >= 0);
            mod_acc = mod_acc + mod_code - (y ? 32768 : -32768);
        end else begin
            y = pat[pidx % plen];
            pidx++;
        end
        return y;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist[k] = 0;
        nb       = 0;
        n_strobe = 0;
        sb.delete();
        pidx    = 0;
        mod_acc = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset  = 1'b1;
        bit_en = 1'b0;
        din    = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_bits(input int nbits, input int duty);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < nbits && guard < 20000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 99) < duty) begin
                bit_en = 1'b1;
                din    = gen_bit();
                model_bit(din);
                sent++;
            end else begin
                bit_en = 1'b0;
                din    = 1'($urandom_range(0, 1));
            end
        end
        if (sent < nbits) check("run_bits_budget", sent, nbits);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_en = 1'b0;
            din    = 1'b0;
        end
    endtask

    vec_t tv[6];
    int   b2[2*R-1];
    int   diff;
    int   codes[2];

    initial begin
        reset   = 1'b1;
        bit_en  = 1'b0;
        din     = 1'b0;
        use_mod = 1'b0;
        pat     = 8'd0;
        plen    = 1;
        mod_code = 0;
        last_dout = '0;

        for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
        for (int i = 0; i < HL; i++) h[i] = 0;
        for (int j = 0; j < R; j++)
            for (int k = 0; k < R; k++) b2[j+k] += 1;
        for (int i = 0; i < 2*R-1; i++)
            for (int k = 0; k < R; k++) h[i+k] += b2[i];
        model_reset();

        // {pattern (bit0 first), length, bit_en duty %, expected settled dout}
        tv[0] = '{8'b0000_0001, 1, 100, 16'h7FFF};
        tv[1] = '{8'b0000_0000, 1, 100, 16'h8000};
        tv[2] = '{8'b0000_0111, 4, 100, 16'h4000};
        tv[3] = '{8'b0000_0001, 2, 100, 16'h0000};
        tv[4] = '{8'b0000_0001, 1, 30,  16'h7FFF};
        tv[5] = '{8'b0000_0001, 4, 100, 16'hC000};

        repeat (3) @(negedge clk);
        check("reset_dout", {16'd0, dout}, 32'd0);
        check("reset_valid", {31'd0, dout_valid}, 32'd0);
        check("reset_settled", {31'd0, settled}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            use_mod = 1'b0;
            pat     = tv[i].pat;
            plen    = tv[i].plen;
            run_bits(8 * R, tv[i].duty);
            idle(6);
            check("steady_dout", {16'd0, last_dout}, {16'd0, tv[i].exp});
            check("steady_settled", {31'd0, settled}, 32'd1);
            check("sb_drained", sb.size(), 32'd0);
        end

        // Reset 37 bits into a period: immediate clear, fresh 64-bit period after release.
        apply_reset();
        pat  = 8'b0000_0001;
        plen = 1;
        run_bits(4 * R + 37, 100);
        @(negedge clk);
        check("pre_reset_settled", {31'd0, settled}, 32'd1);
        reset  = 1'b1;
        bit_en = 1'b0;
        #1;
        check("midreset_dout", {16'd0, dout}, 32'd0);
        check("midreset_valid", {31'd0, dout_valid}, 32'd0);
        check("midreset_settled", {31'd0, settled}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_bits(R - 1, 100);
        idle(6);
        check("no_early_strobe", n_strobe, 32'd0);
        check("sb_after_63", sb.size(), 32'd0);
        run_bits(1, 100);
        idle(6);
        check("strobe_after_64", n_strobe, 32'd1);
        check("sb_after_reset", sb.size(), 32'd0);

        // Loopback from a first-order modulator; long run wraps I3 many times.
        codes[0] = 16384;
        codes[1] = -16384;
        for (int i = 0; i < 2; i++) begin
            apply_reset();
            use_mod  = 1'b1;
            mod_code = codes[i];
            run_bits(40 * R, 100);
            idle(6);
            diff = int'($signed(last_dout)) - codes[i];
            check("loopback_level", {31'd0, (diff <= 64 && diff >= -64)}, 32'd1);
            check("loopback_drained", sb.size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
